// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning the architectural HI/LO pair; results sit in shadow registers until the busy countdown ends.
// Define MULDIV_MADD_EN to enable ops 1xx (MADD/MADDU/MSUB/MSUBU), which accumulate into {HI,LO}.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; mthi/mtlo loads and new starts accepted
// RUN   | countdown active; shadow result committed when it reaches zero

module muldiv_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    input  logic        start,
    input  logic [31:0] load,
    input  logic        load_HI,
    input  logic        load_LO,
    input  logic        revoke,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic [7:0]  count_down
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [7:0] MUL_CNT = 8'(MUL_CYCLES);
    localparam logic [7:0] DIV_CNT = 8'(DIV_CYCLES);

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] shadow_hi_q, shadow_hi_d, shadow_lo_q, shadow_lo_d;

    logic        op_legal;
    logic [7:0]  op_cycles;
    logic [63:0] result;

    // Products
    logic [63:0] prod_s, prod_u;
    assign prod_u = {32'd0, A} * {32'd0, B};
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});

    // Division runs on magnitudes; divisor is forced nonzero so the
    // divide-by-zero result is chosen explicitly below.
    logic [31:0] div_u, qu, ru;
    logic [31:0] abs_a, abs_b, div_s, qs_mag, rs_mag, qs, rs;
    assign div_u  = (B == 32'd0) ? 32'd1 : B;
    assign qu     = A / div_u;
    assign ru     = A % div_u;
    assign abs_a  = A[31] ? -A : A;
    assign abs_b  = B[31] ? -B : B;
    assign div_s  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    assign qs_mag = abs_a / div_s;
    assign rs_mag = abs_a % div_s;
    assign qs     = (A[31] ^ B[31]) ? -qs_mag : qs_mag;
    assign rs     = A[31] ? -rs_mag : rs_mag;

`ifdef MULDIV_MADD_EN
    logic [63:0] acc, acc_prod, madd_res;
    assign acc      = {hi_q, lo_q};
    assign acc_prod = op[0] ? prod_u : prod_s;
    assign madd_res = op[1] ? (acc - acc_prod) : (acc + acc_prod);
    assign op_legal = 1'b1;
`else
    assign op_legal = ~op[2];
`endif

    assign op_cycles = (op[2:1] == 2'b01) ? DIV_CNT : MUL_CNT;

    always_comb begin
        result = 64'd0;
        case (op)
            3'b000:  result = prod_s;
            3'b001:  result = prod_u;
            3'b010:  result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {rs, qs};
            3'b011:  result = (B == 32'd0) ? {A, 32'hFFFF_FFFF} : {ru, qu};
`ifdef MULDIV_MADD_EN
            default: result = madd_res;
`else
            default: result = 64'd0;
`endif
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        shadow_hi_d = shadow_hi_q;
        shadow_lo_d = shadow_lo_q;
        case (state_q)
            S_IDLE: begin
                // revoke kills both starts and loads; any start (even illegal) drops a load
                if (!revoke) begin
                    if (start) begin
                        if (op_legal) begin
                            state_d     = S_RUN;
                            count_d     = op_cycles;
                            shadow_hi_d = result[63:32];
                            shadow_lo_d = result[31:0];
                        end
                    end else begin
                        if (load_HI) hi_d = load;
                        if (load_LO) lo_d = load;
                    end
                end
            end
            S_RUN: begin
                if (revoke) begin
                    state_d = S_IDLE;
                    count_d = 8'd0;
                end else if (count_q == 8'd1) begin
                    state_d = S_IDLE;
                    count_d = 8'd0;
                    hi_d    = shadow_hi_q;
                    lo_d    = shadow_lo_q;
                end else begin
                    count_d = count_q - 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                count_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q     <= 8'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            shadow_hi_q <= 32'd0;
            shadow_lo_q <= 32'd0;
        end else begin
            count_q     <= count_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            shadow_hi_q <= shadow_hi_d;
            shadow_lo_q <= shadow_lo_d;
        end
    end

    assign HI         = hi_q;
    assign LO         = lo_q;
    assign busy       = (state_q == S_RUN);
    assign count_down = count_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against a longint reference model.
// Honours MULDIV_MADD_EN the same way as the design.

module tb_muldiv_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        reset;
    logic [31:0] A, B, load;
    logic [2:0]  op;
    logic        start, load_HI, load_LO, revoke;
    logic [31:0] HI, LO;
    logic        busy;
    logic [7:0]  count_down;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    muldiv_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
        .load(load), .load_HI(load_HI), .load_LO(load_LO), .revoke(revoke),
        .HI(HI), .LO(LO), .busy(busy), .count_down(count_down)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit legal_op(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
        return 1'b1;
`else
        return (o[2] == 1'b0);
`endif
    endfunction

    // Reference: returns {HI,LO} from plain 64-bit arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                p = ua / ub;
                return {32'(ua % ub), p[31:0]};
            end
            default: begin
                p = o[0] ? (ua * ub) : 64'(sa * sb);
                return o[1] ? (acc - p) : (acc + p);
            end
        endcase
    endfunction

    task automatic clear_inputs();
        start = 1'b0; load_HI = 1'b0; load_LO = 1'b0; revoke = 1'b0;
    endtask

    // Called at a negedge; leaves at a negedge.
    task automatic do_load(input bit hi_en, input bit lo_en, input logic [31:0] val);
        load = val; load_HI = hi_en; load_LO = lo_en;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        if (hi_en) model_hi = val;
        if (lo_en) model_lo = val;
        check_eq("load_hi", HI, model_hi);
        check_eq("load_lo", LO, model_lo);
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit with_load);
        logic [63:0] exp;
        int n;
        exp = ref_result(o, a, b, {model_hi, model_lo});
        n = (o == 3'd2 || o == 3'd3) ? DIV_N : MUL_N;
        op = o; A = a; B = b; start = 1'b1;
        load = 32'hBEEF; load_LO = with_load;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        A = $urandom; B = $urandom;
        if (!legal_op(o)) begin
            check_eq({tag, "_ign_busy"}, busy, 0);
            check_eq({tag, "_ign_hi"}, HI, model_hi);
            check_eq({tag, "_ign_lo"}, LO, model_lo);
            return;
        end
        for (int i = 0; i < n; i++) begin
            check_eq({tag, "_busy"}, busy, 1);
            check_eq({tag, "_cnt"}, count_down, 64'(n - i));
            check_eq({tag, "_hold_lo"}, LO, model_lo);
            @(negedge clk);
        end
        model_hi = exp[63:32];
        model_lo = exp[31:0];
        check_eq({tag, "_done_busy"}, busy, 0);
        check_eq({tag, "_done_cnt"}, count_down, 0);
        check_eq({tag, "_hi"}, HI, model_hi);
        check_eq({tag, "_lo"}, LO, model_lo);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        clear_inputs();
        A = 0; B = 0; op = 0; load = 0;
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_cnt", count_down, 0);
        check_eq("rst_hi", HI, 0);
        check_eq("rst_lo", LO, 0);
        reset = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a DIV
        do_load(1, 1, 32'hA5A5_0001);
        op = 3'd2; A = 32'd100; B = 32'd3; start = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        @(negedge clk); @(negedge clk);
        check_eq("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_cnt", count_down, 0);
        check_eq("arst_hi", HI, 0);
        check_eq("arst_lo", LO, 0);
        #1 reset = 1'b0;
        model_hi = 0; model_lo = 0;
        @(negedge clk);

        run_op("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        check_eq("mult_hi_c", HI, 32'hFFFF_FFFF);
        check_eq("mult_lo_c", LO, 32'hFFFF_FFEB);
        run_op("multu", 3'd1, 32'hFFFF_FFFD, 32'd7, 0);
        check_eq("multu_hi_c", HI, 32'h0000_0006);
        check_eq("multu_lo_c", LO, 32'hFFFF_FFEB);
        run_op("divu", 3'd3, 32'd100, 32'd7, 0);
        check_eq("divu_c", {HI, LO}, {32'd2, 32'd14});
        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check_eq("div_neg_c", {HI, LO}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check_eq("div_ovf_c", {HI, LO}, {32'd0, 32'h8000_0000});
        run_op("divu_z", 3'd3, 32'd5, 32'd0, 0);
        check_eq("divu_z_c", {HI, LO}, {32'd5, 32'hFFFF_FFFF});

        // Revoke on the 3rd busy cycle
        do_load(1, 0, 32'h11);
        do_load(0, 1, 32'h22);
        op = 3'd0; A = 32'd3; B = 32'd4; start = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        @(negedge clk); @(negedge clk);
        revoke = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        check_eq("rev_busy", busy, 0);
        check_eq("rev_cnt", count_down, 0);
        check_eq("rev_hi", HI, 32'h11);
        check_eq("rev_lo", LO, 32'h22);
        @(negedge clk); @(negedge clk);
        check_eq("rev_lo_late", LO, 32'h22);

        // Revoke with start / with load in idle
        op = 3'd0; A = 32'd9; B = 32'd9; start = 1'b1; revoke = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        check_eq("rev_start_busy", busy, 0);
        check_eq("rev_start_lo", LO, 32'h22);
        load = 32'hCAFE; load_HI = 1'b1; revoke = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        check_eq("rev_load_hi", HI, 32'h11);

        do_load(1, 0, 32'h1234_5678);
        check_eq("mthi", HI, 32'h1234_5678);

        // Load while busy is ignored
        op = 3'd0; A = 32'd2; B = 32'd3; start = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        load = 32'hDEAD; load_LO = 1'b1;
        @(posedge clk); @(negedge clk);
        clear_inputs();
        check_eq("busy_load_lo", LO, model_lo);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check_eq("busy_load_done", busy, 0);
        check_eq("busy_load_res", {HI, LO}, 64'd6);
        model_hi = 0; model_lo = 6;

        run_op("start_load", 3'd0, 32'd5, 32'd5, 1);
        check_eq("start_load_lo", LO, 32'd25);

        // MADDU 1*1 on {0, 0xFFFFFFFF}
        do_load(1, 1, 32'd0);
        do_load(0, 1, 32'hFFFF_FFFF);
        run_op("maddu", 3'd5, 32'd1, 32'd1, 0);
`ifdef MULDIV_MADD_EN
        check_eq("maddu_c", {HI, LO}, {32'd1, 32'd0});
`else
        check_eq("maddu_ign", {HI, LO}, {32'd0, 32'hFFFF_FFFF});
`endif

        // Illegal/ignored start also drops a same-cycle load
`ifndef MULDIV_MADD_EN
        run_op("ill_load", 3'd6, 32'd3, 32'd3, 1);
`endif

        for (int k = 0; k < 24; k++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 16));
                default: ;
            endcase
            run_op("rnd", r_op, r_a, r_b, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
